kore_opdispatch: RTL and testbench

Parametrised instruction-dispatch FSM for the kore core. It accepts a 32-bit instruction word from the IR stage over a valid/ready handshake and decodes opcode, rs0, rs1, rd and the branch-compare flag. It issues the decoded operation to one of NFU function units, then waits for that unit's end-of-operation before it accepts the next instruction. A watchdog reports a unit that never returns eop.

---
 rtl/kore_pkg.sv | 24 ++
 rtl/kore_ir_fields.sv | 27 ++
 rtl/kore_opdispatch.sv | 156 +++++++++++++++
 tb/tb_kore_opdispatch.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kore_pkg.sv
// Shared types and instruction-field positions for the kore dispatch logic.
package kore_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } kore_state_e;

  // LSB positions of the instruction-word fields
  localparam int OPC = 0;
  localparam int RD  = 7;
  localparam int F3  = 12;
  localparam int RS0 = 15;
  localparam int RS1 = 20;
  localparam int TGT = 2;

  localparam int OPC_W = 7;
  localparam int REG_W = 5;
  localparam int F3_W  = 3;

  localparam logic [F3_W-1:0] BC_F3 = 3'b111;

endpackage

// File: rtl/kore_ir_fields.sv
// Combinational instruction-word field extractor; out-of-range unit
// indices fold back to unit 0.
module kore_ir_fields
  import kore_pkg::*;
#(
  parameter int NFU = 2
) (
  input  logic [31:0]      ir_code,
  output logic [OPC_W-1:0] opcode,
  output logic [REG_W-1:0] rs0,
  output logic [REG_W-1:0] rs1,
  output logic [REG_W-1:0] rd,
  output logic             bc,
  output logic [1:0]       tgt
);

  logic [1:0] tgt_raw;

  assign opcode  = ir_code[OPC +: OPC_W];
  assign rs0     = ir_code[RS0 +: REG_W];
  assign rs1     = ir_code[RS1 +: REG_W];
  assign rd      = ir_code[RD  +: REG_W];
  assign bc      = (ir_code[F3 +: F3_W] == BC_F3);
  assign tgt_raw = ir_code[TGT +: 2];
  assign tgt     = (32'(tgt_raw) >= NFU) ? 2'd0 : tgt_raw;

endmodule

// File: rtl/kore_opdispatch.sv
// Instruction dispatch FSM: accepts one instruction, issues it to a function
// unit and waits for that unit's eop, with a watchdog on the wait.
module kore_opdispatch
  import kore_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NFU     = 2,
  parameter int TMO_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ir_vld,
  output logic             ir_rdy,
  input  logic [31:0]      ir_code,
  input  logic [XLEN-1:0]  pc_in,
  output logic             op_vld,
  input  logic [NFU-1:0]   op_rdy,
  output logic [NFU-1:0]   op_sel,
  output logic [6:0]       opcode,
  output logic [4:0]       pcdata_rs0,
  output logic [4:0]       pcdata_rs1,
  output logic [4:0]       pcdata_rd,
  output logic             pcdata_bc,
  output logic [XLEN-1:0]  pc_out,
  input  logic [NFU-1:0]   eop,
  output logic             opflag,
  output logic             err,
  output logic             busy
);

  localparam int CW = $clog2(TMO_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);

  kore_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            opflag_q, opflag_d;
  logic            err_q, err_d;
  logic            load;

  logic [NFU-1:0]  op_sel_q;
  logic [6:0]      opcode_q;
  logic [4:0]      rs0_q, rs1_q, rd_q;
  logic            bc_q;
  logic [XLEN-1:0] pc_q;

  logic [6:0]      f_opcode;
  logic [4:0]      f_rs0, f_rs1, f_rd;
  logic            f_bc;
  logic [1:0]      f_tgt;
  logic [NFU-1:0]  sel_new;
  logic            rdy_hit, eop_hit;

  kore_ir_fields #(.NFU(NFU)) u_fields (
    .ir_code (ir_code),
    .opcode  (f_opcode),
    .rs0     (f_rs0),
    .rs1     (f_rs1),
    .rd      (f_rd),
    .bc      (f_bc),
    .tgt     (f_tgt)
  );

  assign sel_new = NFU'(1) << f_tgt;
  // op_sel_q is one-hot, so masking ignores every non-target unit
  assign rdy_hit = |(op_rdy & op_sel_q);
  assign eop_hit = |(eop & op_sel_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opflag_d = 1'b0;
    err_d    = err_q;
    load     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ir_vld) begin
          load    = 1'b1;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (rdy_hit) begin
          if (eop_hit) begin
            state_d  = IDLE;
            opflag_d = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        if (eop_hit) begin
          state_d  = IDLE;
          opflag_d = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          state_d  = IDLE;
          opflag_d = 1'b1;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opflag_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opflag_q <= opflag_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_sel_q <= '0;
      opcode_q <= '0;
      rs0_q    <= '0;
      rs1_q    <= '0;
      rd_q     <= '0;
      bc_q     <= 1'b0;
      pc_q     <= '0;
    end else if (load) begin
      op_sel_q <= sel_new;
      opcode_q <= f_opcode;
      rs0_q    <= f_rs0;
      rs1_q    <= f_rs1;
      rd_q     <= f_rd;
      bc_q     <= f_bc;
      pc_q     <= pc_in;
    end
  end

  assign ir_rdy     = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign op_vld     = (state_q == ISSUE);
  assign op_sel     = op_sel_q;
  assign opcode     = opcode_q;
  assign pcdata_rs0 = rs0_q;
  assign pcdata_rs1 = rs1_q;
  assign pcdata_rd  = rd_q;
  assign pcdata_bc  = bc_q;
  assign pc_out     = pc_q;
  assign opflag     = opflag_q;
  assign err        = err_q;

endmodule

// File: tb/tb_kore_opdispatch.sv
// Directed bench for kore_opdispatch with NFU=2 and a short watchdog.
module tb_kore_opdispatch;

  localparam int XLEN    = 32;
  localparam int NFU     = 2;
  localparam int TMO_CYC = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ir_vld;
  logic            ir_rdy;
  logic [31:0]     ir_code;
  logic [XLEN-1:0] pc_in;
  logic            op_vld;
  logic [NFU-1:0]  op_rdy;
  logic [NFU-1:0]  op_sel;
  logic [6:0]      opcode;
  logic [4:0]      pcdata_rs0, pcdata_rs1, pcdata_rd;
  logic            pcdata_bc;
  logic [XLEN-1:0] pc_out;
  logic [NFU-1:0]  eop;
  logic            opflag, err, busy;

  int vectors = 0;
  int miscompares = 0;

  kore_opdispatch #(.XLEN(XLEN), .NFU(NFU), .TMO_CYC(TMO_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ir_vld     (ir_vld),
    .ir_rdy     (ir_rdy),
    .ir_code    (ir_code),
    .pc_in      (pc_in),
    .op_vld     (op_vld),
    .op_rdy     (op_rdy),
    .op_sel     (op_sel),
    .opcode     (opcode),
    .pcdata_rs0 (pcdata_rs0),
    .pcdata_rs1 (pcdata_rs1),
    .pcdata_rd  (pcdata_rd),
    .pcdata_bc  (pcdata_bc),
    .pc_out     (pc_out),
    .eop        (eop),
    .opflag     (opflag),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".ir_rdy"}, 64'(ir_rdy), 64'd1);
    chk({tag, ".busy"},   64'(busy),   64'd0);
    chk({tag, ".op_vld"}, 64'(op_vld), 64'd0);
    chk({tag, ".op_sel"}, 64'(op_sel), 64'd0);
    chk({tag, ".opcode"}, 64'(opcode), 64'd0);
    chk({tag, ".rs0"},    64'(pcdata_rs0), 64'd0);
    chk({tag, ".rs1"},    64'(pcdata_rs1), 64'd0);
    chk({tag, ".rd"},     64'(pcdata_rd),  64'd0);
    chk({tag, ".bc"},     64'(pcdata_bc),  64'd0);
    chk({tag, ".pc_out"}, 64'(pc_out), 64'd0);
    chk({tag, ".opflag"}, 64'(opflag), 64'd0);
    chk({tag, ".err"},    64'(err),    64'd0);
  endtask

  logic [31:0] ir_bc, ir_oob;

  initial begin
    rst_n   = 1'b0;
    ir_vld  = 1'b0;
    ir_code = '0;
    pc_in   = '0;
    op_rdy  = '0;
    eop     = '0;
    // rd=9 rs0=4 rs1=5 f3=111 opcode=0x07 (bits[3:2]=01 -> unit 1)
    ir_bc  = {7'h00, 5'd5, 5'd4, 3'b111, 5'd9, 7'h07};
    // opcode=0x0F has bits[3:2]=11, out of range for NFU=2 -> unit 0
    ir_oob = {7'h00, 5'd7, 5'd6, 3'b010, 5'd8, 7'h0F};

    #1;
    chk_reset_vals("reset");
    step();
    step();
    rst_n = 1'b1;
    step();

    // Basic R-type decode on unit 0
    ir_code = 32'h0020_81B3;
    pc_in   = 32'h0000_1000;
    ir_vld  = 1'b1;
    step();
    ir_vld = 1'b0;
    chk("t1.op_vld", 64'(op_vld), 64'd1);
    chk("t1.ir_rdy", 64'(ir_rdy), 64'd0);
    chk("t1.busy",   64'(busy),   64'd1);
    chk("t1.opcode", 64'(opcode), 64'h33);
    chk("t1.rd",     64'(pcdata_rd),  64'd3);
    chk("t1.rs0",    64'(pcdata_rs0), 64'd1);
    chk("t1.rs1",    64'(pcdata_rs1), 64'd2);
    chk("t1.bc",     64'(pcdata_bc),  64'd0);
    chk("t1.op_sel", 64'(op_sel), 64'b01);
    chk("t1.pc_out", 64'(pc_out), 64'h1000);
    op_rdy = 2'b01;
    step();
    op_rdy = 2'b00;
    chk("t1.wait_op_vld", 64'(op_vld), 64'd0);
    chk("t1.wait_busy",   64'(busy),   64'd1);
    eop = 2'b01;
    step();
    eop = 2'b00;
    chk("t1.opflag", 64'(opflag), 64'd1);
    chk("t1.done_ir_rdy", 64'(ir_rdy), 64'd1);
    chk("t1.err", 64'(err), 64'd0);
    step();
    chk("t1.opflag_one_cycle", 64'(opflag), 64'd0);

    // eop while idle has no effect
    eop = 2'b11;
    step();
    eop = 2'b00;
    chk("idle_eop.opflag", 64'(opflag), 64'd0);
    chk("idle_eop.busy",   64'(busy),   64'd0);

    // Branch-compare on unit 1; wrong-unit ready and eop are ignored
    ir_code = ir_bc;
    pc_in   = 32'h0000_2000;
    ir_vld  = 1'b1;
    step();
    ir_vld = 1'b0;
    chk("t2.bc",     64'(pcdata_bc),  64'd1);
    chk("t2.op_sel", 64'(op_sel),     64'b10);
    chk("t2.rd",     64'(pcdata_rd),  64'd9);
    chk("t2.rs0",    64'(pcdata_rs0), 64'd4);
    chk("t2.rs1",    64'(pcdata_rs1), 64'd5);
    chk("t2.opcode", 64'(opcode),     64'h07);
    op_rdy = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2.op_vld_held", 64'(op_vld), 64'd1);
    end
    op_rdy = 2'b10;
    step();
    op_rdy = 2'b00;
    chk("t2.op_vld_drop", 64'(op_vld), 64'd0);
    eop = 2'b01;
    step();
    eop = 2'b00;
    chk("t2.wrong_eop_opflag", 64'(opflag), 64'd0);
    chk("t2.wrong_eop_busy",   64'(busy),   64'd1);
    eop = 2'b10;
    step();
    eop = 2'b00;
    chk("t2.opflag", 64'(opflag), 64'd1);
    chk("t2.ir_rdy", 64'(ir_rdy), 64'd1);
    chk("t2.pc_out_stable", 64'(pc_out), 64'h2000);
    step();
    chk("t2.opflag_one_cycle", 64'(opflag), 64'd0);

    // Out-of-range unit index folds to 0; watchdog timeout
    ir_code = ir_oob;
    pc_in   = 32'h0000_3000;
    ir_vld  = 1'b1;
    step();
    ir_vld = 1'b0;
    chk("t3.op_sel", 64'(op_sel), 64'b01);
    op_rdy = 2'b10;
    step();
    chk("t3.wrong_rdy_op_vld", 64'(op_vld), 64'd1);
    op_rdy = 2'b01;
    step();
    op_rdy = 2'b00;
    for (int i = 0; i < TMO_CYC - 1; i++) begin
      step();
      chk("t3.pre_tmo_opflag", 64'(opflag), 64'd0);
      chk("t3.pre_tmo_busy",   64'(busy),   64'd1);
    end
    step();
    chk("t3.tmo_opflag", 64'(opflag), 64'd1);
    chk("t3.tmo_err",    64'(err),    64'd1);
    chk("t3.tmo_ir_rdy", 64'(ir_rdy), 64'd1);
    step();
    chk("t3.opflag_one_cycle", 64'(opflag), 64'd0);
    chk("t3.err_sticky",       64'(err),    64'd1);
    step();
    chk("t3.err_sticky2",      64'(err),    64'd1);

    // Next acceptance clears err; eop with op_rdy skips WAIT
    ir_code = 32'h0020_81B3;
    pc_in   = 32'h0000_4000;
    ir_vld  = 1'b1;
    step();
    ir_vld = 1'b0;
    chk("t4.err_cleared", 64'(err), 64'd0);
    op_rdy = 2'b01;
    eop    = 2'b01;
    step();
    op_rdy = 2'b00;
    eop    = 2'b00;
    chk("t4.opflag", 64'(opflag), 64'd1);
    chk("t4.ir_rdy", 64'(ir_rdy), 64'd1);
    chk("t4.op_vld", 64'(op_vld), 64'd0);

    // Async reset mid-WAIT discards the op
    ir_code = ir_bc;
    pc_in   = 32'h0000_5000;
    ir_vld  = 1'b1;
    step();
    ir_vld = 1'b0;
    op_rdy = 2'b10;
    step();
    op_rdy = 2'b00;
    step();
    chk("t5.in_wait", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t5.mid_reset");
    step();
    chk("t5.no_opflag", 64'(opflag), 64'd0);
    rst_n = 1'b1;
    step();
    ir_code = 32'h0020_81B3;
    pc_in   = 32'h0000_6000;
    ir_vld  = 1'b1;
    step();
    ir_vld = 1'b0;
    chk("t5.fresh_op_vld", 64'(op_vld), 64'd1);
    chk("t5.fresh_opcode", 64'(opcode), 64'h33);
    chk("t5.fresh_pc_out", 64'(pc_out), 64'h6000);
    op_rdy = 2'b01;
    step();
    op_rdy = 2'b00;
    eop = 2'b01;
    step();
    eop = 2'b00;
    chk("t5.fresh_opflag", 64'(opflag), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
